dbus_wait_responder: RTL and testbench
======================================

# dbus_wait_responder

Data-bus slave that answers CPU memory-stage loads and stores from an internal word-addressed SRAM and throttles the pipeline through `o_WaitReq`. It sits on the CPU data bus behind the DBus translator and is the source of the wait request the hazard logic registers to freeze the pipeline. Access latency is a fixed, parameterised number of wait states, so the stall path is exercised deterministically.

## Interface
- `WAIT_CYCLES`, 2: extra wait states per access. Range 0..15.
- `ADDR_W`, 10: word-address width. SRAM depth is 2^ADDR_W 32-bit words.
- `i_Clk`  in  1  clock; all state is updated on the rising edge.
- `i_Rst`  in  1  reset. Asynchronous, active-high.
- `i_Addr`  in  32  byte address. Bits [1:0] are ignored; bits [ADDR_W+1:2] select the word.
- `i_RdEn`  in  1  read request. Held until it completes.
- `i_WrEn`  in  1  write request. Held until it completes.
- `i_ByteEn`  in  4  write byte lanes; bit n enables `i_WrData[8n+7:8n]`.
- `i_WrData`  in  32  write data.
- `o_RdData`  out  32  registered read data. Valid in the completion cycle; held until the next read completes.
- `o_WaitReq`  out  1  combinational stall request to the master.
- `o_Err`  out  1  access error flag, registered. Only active with `DBUS_RESP_ERR_EN` (see Configuration).

## Operation
- A request exists when `req = i_RdEn | i_WrEn`. If both are asserted, the access is a write.
- Master rule: while `o_WaitReq=1`, the master holds `i_Addr`, `i_ByteEn`, `i_WrData` and the enables stable.
- State machine has three states: IDLE, WAIT, DONE.
  - IDLE: if `req`, load the counter with `WAIT_CYCLES` and go to WAIT. Otherwise stay in IDLE.
  - WAIT, `req` low: abort. Go to IDLE; no write is committed.
  - WAIT, `req` high, counter ≠ 0: decrement the counter.
  - WAIT, `req` high, counter = 0: perform the access and go to DONE.
    - Write: commit the enabled bytes to the SRAM.
    - Read: register the SRAM word into `o_RdData`.
  - DONE: go to IDLE unconditionally.
- `o_WaitReq = req & (state != DONE)`.
- Back-to-back requests: a request still asserted in the cycle after DONE is a new transaction (state is IDLE).
- `o_RdData` changes only on read completion or reset.
- Write with `i_ByteEn=0`: completes with normal timing and changes nothing.

## Timing
- Reset values: state IDLE, counter 0, `o_RdData`=0, `o_Err`=0. `o_WaitReq` is 0 whenever `req` is low.
- SRAM contents are not reset.
- For a request first seen in cycle 0:
  - `o_WaitReq` is high in cycles 0..WAIT_CYCLES+1.
  - The cycle WAIT_CYCLES+2 is the completion cycle: `o_WaitReq`=0 and data is valid.
  - Minimum access (WAIT_CYCLES=0) is 3 cycles, 2 of them stalled.
- Reset asserted mid-WAIT: the write is not committed, `o_RdData` is unchanged from its reset value of 0, and the FSM returns to IDLE immediately.
- Counter width is 4 bits. Decrement never wraps, because the counter is only decremented when ≠ 0.

## Configuration
- `DBUS_RESP_ERR_EN` defined:
  - An access with `i_Addr[31:ADDR_W+2] != 0`, or with `i_RdEn & i_WrEn`, is an error.
  - The access still follows the normal wait timing.
  - Error write: not committed.
  - Error read: loads `o_RdData`=0.
  - `o_Err`=1 for exactly the DONE cycle.
- `DBUS_RESP_ERR_EN` undefined:
  - Upper address bits are ignored, so addresses alias.
  - Simultaneous `i_RdEn` and `i_WrEn` is treated as a write.
  - `o_Err` is tied to 0.

## Test plan
- Reset, then WAIT_CYCLES=2: write `0xDEADBEEF` to 0x10 with ByteEn=4'hF. Expect `o_WaitReq` high for exactly 4 cycles, then one cycle low.
- Read 0x10 after that write. Expect 4 stall cycles, then `o_RdData`=`0xDEADBEEF` in the completion cycle, and the value held afterwards.
- Write `0x000000AA` to 0x10 with ByteEn=4'b0001, then read 0x10. Expect `0xDEADBEAA`.
- Assert a write of `0x12345678` to 0x20, then drop `req` after 1 stall cycle. Expect the FSM to return to IDLE. A following read of 0x20 returns the prior value, i.e. no commit.
- Back-to-back reads of 0x10 and 0x14 with `req` held continuously. Expect two 4-cycle stall windows separated by one completion cycle.
- With `DBUS_RESP_ERR_EN` defined, read 0xFFFF0000. Expect `o_RdData`=0 and `o_Err`=1 for one cycle. Without the macro, the same address aliases to word 0 and `o_Err`=0.

Source files
------------

// File: rtl/dbus_wait_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dbus_wait_responder                                          |
// | Description : Data-bus slave backed by a word-addressed SRAM. Every access |
// |               is answered after a fixed number of wait states, and the    |
// |               pipeline is stalled through o_WaitReq while it is pending.  |
// | Ports       : i_Clk, i_Rst (async, active-high)                            |
// |               i_Addr[31:0]   byte address, bits [ADDR_W+1:2] pick a word   |
// |               i_RdEn, i_WrEn request strobes, held until completion       |
// |               i_ByteEn[3:0], i_WrData[31:0] write lanes and data          |
// |               o_RdData[31:0] registered read data, held between reads     |
// |               o_WaitReq      combinational stall request                  |
// |               o_Err          registered error flag for the DONE cycle     |
// | Options     : `define DBUS_RESP_ERR_EN enables out-of-range and            |
// |               read+write error detection; otherwise addresses alias and   |
// |               o_Err is tied low.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dbus_wait_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [31:0] i_Addr,
  input  logic        i_RdEn,
  input  logic        i_WrEn,
  input  logic [3:0]  i_ByteEn,
  input  logic [31:0] i_WrData,
  output logic [31:0] o_RdData,
  output logic        o_WaitReq,
  output logic        o_Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic [3:0]            cnt_nxt;
  logic                  access;
  logic                  req;
  logic                  acc_err;
  logic                  err_q;
  logic [31:0]           rd_data_q;
  logic [ADDR_W-1:0]     word_idx;
  logic [31:0]           mem [0:(1<<ADDR_W)-1];

  // Address bits outside the word index only matter for error detection.
  logic                  unused_bits;
  assign unused_bits = ^{i_Addr[31:ADDR_W+2], i_Addr[1:0]};

  assign req      = i_RdEn | i_WrEn;
  assign word_idx = i_Addr[ADDR_W+1:2];

`ifdef DBUS_RESP_ERR_EN
  assign acc_err = (i_Addr[31:ADDR_W+2] != '0) | (i_RdEn & i_WrEn);
`else
  assign acc_err = 1'b0;
`endif

  // DONE suppresses the stall even if the master keeps requesting, which is
  // what gives back-to-back transactions their single completion cycle.
  assign o_WaitReq = req & (state != S_DONE);
  assign o_RdData  = rd_data_q;
  assign o_Err     = err_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (!req) begin
          // Master withdrew the request: abandon without committing.
          state_nxt = S_IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // SRAM contents are deliberately not reset.
  always_ff @(posedge i_Clk) begin
    if (access && i_WrEn && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (i_ByteEn[b]) begin
          mem[word_idx][8*b +: 8] <= i_WrData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= access & acc_err;
      // A simultaneous read+write is a write, so only pure reads load data.
      if (access && !i_WrEn) begin
        rd_data_q <= acc_err ? 32'd0 : mem[word_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_wait_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dbus_wait_responder                                       |
// | Description : Self-checking bench for dbus_wait_responder. A transaction- |
// |               level model supplies the expected stall/data/error outputs  |
// |               for every cycle; literal checks pin the model itself.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dbus_wait_responder;

  localparam int W  = 2;
  localparam int AW = 10;

  logic        i_Clk;
  logic        i_Rst;
  logic [31:0] i_Addr;
  logic        i_RdEn;
  logic        i_WrEn;
  logic [3:0]  i_ByteEn;
  logic [31:0] i_WrData;
  logic [31:0] o_RdData;
  logic        o_WaitReq;
  logic        o_Err;

  dbus_wait_responder #(
    .WAIT_CYCLES (W),
    .ADDR_W      (AW)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Addr   (i_Addr),
    .i_RdEn   (i_RdEn),
    .i_WrEn   (i_WrEn),
    .i_ByteEn (i_ByteEn),
    .i_WrData (i_WrData),
    .o_RdData (o_RdData),
    .o_WaitReq(o_WaitReq),
    .o_Err    (o_Err)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle, maintained by the driver.
  logic        exp_wait;
  logic        exp_err;
  logic [31:0] exp_rd;
  logic [31:0] mdl [int];

  int stall_run  = 0;
  int last_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic wr, input logic rd);
`ifdef DBUS_RESP_ERR_EN
    return ((a >> (AW + 2)) != 32'd0) || (wr && rd);
`else
    return 1'b0 & wr & rd & a[0];
`endif
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge i_Clk) begin
    check("wait_req", {31'd0, o_WaitReq}, {31'd0, exp_wait});
    check("err",      {31'd0, o_Err},     {31'd0, exp_err});
    check("rd_data",  o_RdData,           exp_rd);
    if (o_WaitReq) begin
      stall_run++;
    end else begin
      if (stall_run != 0) last_stall = stall_run;
      stall_run = 0;
    end
  end

  task automatic next_cycle;
    @(posedge i_Clk);
    #1;
  endtask

  // One full access: W+2 stalled cycles, then the completion cycle.
  task automatic txn(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] data, input bit release_req);
    logic        e;
    int          w;
    logic [31:0] old;
    i_WrEn = wr; i_RdEn = rd; i_Addr = addr; i_ByteEn = be; i_WrData = data;
    e = model_err(addr, wr, rd);
    w = word_of(addr);
    exp_wait = 1'b1;
    exp_err  = 1'b0;
    repeat (W + 2) next_cycle();
    exp_wait = 1'b0;
    exp_err  = e;
    if (wr) begin
      if (!e) begin
        old = mdl.exists(w) ? mdl[w] : 32'd0;
        for (int b = 0; b < 4; b++)
          if (be[b]) old[8*b +: 8] = data[8*b +: 8];
        mdl[w] = old;
      end
    end else begin
      exp_rd = e ? 32'd0 : mdl[w];
    end
    next_cycle();
    exp_err = 1'b0;
    if (release_req) begin
      i_WrEn = 1'b0; i_RdEn = 1'b0;
      exp_wait = 1'b0;
      next_cycle();
    end
  endtask

  // Request held for n cycles, then withdrawn before completion.
  task automatic abort_wr(input logic [31:0] addr, input logic [31:0] data, input int n);
    i_WrEn = 1'b1; i_RdEn = 1'b0; i_Addr = addr; i_ByteEn = 4'hF; i_WrData = data;
    exp_wait = 1'b1;
    repeat (n) next_cycle();
    i_WrEn = 1'b0;
    exp_wait = 1'b0;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst = 1'b1; i_Addr = 32'd0; i_RdEn = 1'b0; i_WrEn = 1'b0;
    i_ByteEn = 4'h0; i_WrData = 32'd0;
    exp_wait = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
    repeat (3) next_cycle();
    i_Rst = 1'b0;
    next_cycle();
    check("reset_rd", o_RdData, 32'h0000_0000);

    // Reset in the middle of a write must not commit it.
    txn(1'b1, 1'b0, 32'h30, 4'hF, 32'h1111_2222, 1'b1);
    i_WrEn = 1'b1; i_Addr = 32'h30; i_ByteEn = 4'hF; i_WrData = 32'h3333_4444;
    exp_wait = 1'b1;
    repeat (2) next_cycle();
    i_Rst = 1'b1; i_WrEn = 1'b0;
    exp_wait = 1'b0; exp_rd = 32'd0;
    next_cycle();
    i_Rst = 1'b0;
    next_cycle();
    txn(1'b0, 1'b1, 32'h30, 4'h0, 32'd0, 1'b1);
    check("rst_no_commit", o_RdData, 32'h1111_2222);

    // Basic write then read with full stall window.
    txn(1'b1, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1);
    check("wr_stall_len", 32'(last_stall), 32'd4);
    txn(1'b0, 1'b1, 32'h10, 4'h0, 32'd0, 1'b1);
    check("rd_stall_len", 32'(last_stall), 32'd4);
    check("rd_deadbeef", o_RdData, 32'hDEAD_BEEF);
    repeat (3) next_cycle();
    check("rd_held", o_RdData, 32'hDEAD_BEEF);

    // Single byte lane, then an all-lanes-disabled write.
    txn(1'b1, 1'b0, 32'h10, 4'b0001, 32'h0000_00AA, 1'b1);
    txn(1'b0, 1'b1, 32'h10, 4'h0, 32'd0, 1'b1);
    check("byte_lane", o_RdData, 32'hDEAD_BEAA);
    txn(1'b1, 1'b0, 32'h10, 4'h0, 32'hFFFF_FFFF, 1'b1);
    check("be0_stall_len", 32'(last_stall), 32'd4);
    txn(1'b0, 1'b1, 32'h10, 4'h0, 32'd0, 1'b1);
    check("be0_no_change", o_RdData, 32'hDEAD_BEAA);

    // Aborted writes: early and at the last wait state.
    txn(1'b1, 1'b0, 32'h20, 4'hF, 32'hCAFE_F00D, 1'b1);
    abort_wr(32'h20, 32'h1234_5678, 1);
    txn(1'b0, 1'b1, 32'h20, 4'h0, 32'd0, 1'b1);
    check("abort1_stall_len", 32'(last_stall), 32'd4);
    check("abort1_no_commit", o_RdData, 32'hCAFE_F00D);
    abort_wr(32'h20, 32'h1234_5678, W + 1);
    txn(1'b0, 1'b1, 32'h20, 4'h0, 32'd0, 1'b1);
    check("abort_last_no_commit", o_RdData, 32'hCAFE_F00D);

    // Back-to-back reads with the request held continuously.
    txn(1'b1, 1'b0, 32'h14, 4'hF, 32'h0BAD_C0DE, 1'b1);
    txn(1'b0, 1'b1, 32'h10, 4'h0, 32'd0, 1'b0);
    check("b2b_first_len", 32'(last_stall), 32'd4);
    txn(1'b0, 1'b1, 32'h14, 4'h0, 32'd0, 1'b1);
    check("b2b_second_len", 32'(last_stall), 32'd4);
    check("b2b_second_data", o_RdData, 32'h0BAD_C0DE);

    // High address: alias to word 0, or an error when detection is enabled.
    txn(1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A_5A5A, 1'b1);
    txn(1'b0, 1'b1, 32'hFFFF_0000, 4'h0, 32'd0, 1'b1);
`ifdef DBUS_RESP_ERR_EN
    check("high_addr_err_rd", o_RdData, 32'h0000_0000);
`else
    check("high_addr_alias", o_RdData, 32'h5A5A_5A5A);
`endif

    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
